commit_trace_serializer: RTL and testbench
==========================================

Name: commit_trace_serializer

Overview:
- Synthesizable N-lane writeback commit monitor for the multi-issue core.
- Each cycle it collects register-write commits from LANES writeback channels and serializes them in program order (lane 0 first) into a DEPTH-entry trace FIFO, drained one record per cycle by a downstream consumer (trace comparator or debug UART).
- It also keeps retired-instruction and cycle counters and a sticky end-of-test flag keyed on END_PC.
- Successor to the fixed dual-lane simulation-only trace hookup: it is generalised in lane count and depth, with flow control, overflow accounting and end detection.

Parameters:
- LANES, 2, number of writeback lanes (1..4).
- DEPTH, 16, FIFO entries; power of two, at least 2.
- CNT_W, 32, width of inst_cnt, cycle_cnt and drop_cnt.
- END_PC, 32'hbfc00100, a retiring PC equal to this value ends the test.

Ports:
- clk  in  1  core clock.
- resetn  in  1  asynchronous active-low reset.
- trace_en  in  1  capture enable for FIFO pushes; the counters ignore it.
- wb_valid  in  LANES  lane i retires an instruction this cycle.
- wb_en  in  LANES  lane i writes a register; only meaningful when wb_valid[i] is high.
- wb_rd  in  5*LANES  destination register of lane i, bits [5i+4:5i].
- wb_wdata  in  32*LANES  write data of lane i.
- wb_pc  in  32*LANES  PC of lane i.
- out_valid  out  1  FIFO head is valid.
- out_ready  in  1  consumer accepts the head record.
- out_pc  out  32  head record PC.
- out_rd  out  5  head record destination register.
- out_wdata  out  32  head record write data.
- out_lane  out  2  lane index the head record came from.
- fifo_count  out  $clog2(DEPTH)+1  number of occupied entries.
- inst_cnt  out  CNT_W  retired instructions.
- cycle_cnt  out  CNT_W  cycles counted since reset release.
- drop_cnt  out  CNT_W  records dropped because the FIFO was full.
- overflow  out  1  sticky; set on the first dropped record.
- test_end  out  1  sticky end-of-test flag.

Behaviour:
- Reset: while resetn is low, every output is 0, the FIFO is empty and all pointers are 0. Reset asserted mid-operation discards FIFO contents immediately.
- Candidate record for lane i: trace_en && !test_end && wb_valid[i] && wb_en[i] && wb_rd[i]!=0.
- Candidates are ordered by ascending lane index.
- Push slots available this cycle: free = DEPTH - fifo_count + (pop ? 1 : 0), where pop = out_valid && out_ready.
- The first min(k, free) candidates are written, where k is the number of candidates. Each remaining candidate is dropped.
- On drops: drop_cnt increases by the number of dropped records, saturating at all-ones, and overflow is set.
- Pushes are in order; a later lane never overtakes an earlier one.
- Push and pop in the same cycle are both legal. Pointers wrap modulo DEPTH. fifo_count = count + pushed - popped.
- Latency: a record captured at edge t is visible on out_* after edge t if the FIFO was empty. out_* is driven from the head entry (show-ahead) and is stable while out_valid && !out_ready.
- When out_valid is 0, out_pc, out_rd, out_wdata and out_lane hold their last values; the checker ignores them.
- inst_cnt increases each cycle by popcount(wb_valid) while !test_end, saturating. It is independent of trace_en and wb_en.
- cycle_cnt increases by 1 each cycle while !test_end, saturating.
- test_end sets at the edge where any lane has wb_valid[i] && wb_pc[i]==END_PC.
  - That cycle's retirements are fully counted, and its candidates are pushed normally.
  - From the next cycle on, counters freeze and no further pushes occur.
  - The FIFO keeps draining after test_end.
  - Only reset clears test_end.
- No combinational path from wb_* to out_*. out_ready may combinationally affect only internal push-space calculation.

Test Plan:
- Single-lane fill/drain: LANES=2, DEPTH=4, out_ready=0; 4 cycles of lane-0 commits (pc 0xbfc00000 + 4n, rd=n+1). Expect fifo_count=4, overflow=0. Then out_ready=1: 4 records drain in order, out_valid drops after the 4th.
- Dual-issue ordering: one cycle with lane0 (pc 0x...10, rd 3) and lane1 (pc 0x...14, rd 4). Expect out_lane 0 then 1 on consecutive pops; inst_cnt=2.
- Filtering: lane0 rd=0, lane1 wb_en=0, both wb_valid=1. Expect no push and inst_cnt +2. Same stimulus with trace_en=0 and valid rd: no push, counters still advance.
- Overflow with simultaneous pop: DEPTH=4 with 3 entries, out_ready=1, two candidates. Expect both accepted, fifo_count=4, drop_cnt=0. Next cycle with out_ready=0 and two candidates: drop_cnt=2, overflow=1.
- End detection: lane1 wb_pc=0xbfc00100 with wb_valid=1. Expect test_end=1 after that edge; inst_cnt and cycle_cnt frozen in later cycles despite activity; FIFO still drains.
- Async reset mid-stream: assert resetn=0 between clock edges with fifo_count=3. Expect all outputs 0 immediately. After release, counters restart from 0 and the FIFO is empty.

Source files
------------

// File: rtl/commit_trace_serializer.sv
// Multi-lane writeback commit monitor: serializes register-write commits in lane
// order into a show-ahead trace FIFO and keeps retire/cycle/drop counters.
module commit_trace_serializer #(
    parameter int          LANES  = 2,
    parameter int          DEPTH  = 16,
    parameter int          CNT_W  = 32,
    parameter logic [31:0] END_PC = 32'hbfc00100
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     trace_en,
    input  logic [LANES-1:0]         wb_valid,
    input  logic [LANES-1:0]         wb_en,
    input  logic [5*LANES-1:0]       wb_rd,
    input  logic [32*LANES-1:0]      wb_wdata,
    input  logic [32*LANES-1:0]      wb_pc,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              out_pc,
    output logic [4:0]               out_rd,
    output logic [31:0]              out_wdata,
    output logic [1:0]               out_lane,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic [CNT_W-1:0]         inst_cnt,
    output logic [CNT_W-1:0]         cycle_cnt,
    output logic [CNT_W-1:0]         drop_cnt,
    output logic                     overflow,
    output logic                     test_end
);
    localparam int AW = $clog2(DEPTH);
    localparam int NW = AW + 2;

    logic [31:0]    pc_q [DEPTH];
    logic [4:0]     rd_q [DEPTH];
    logic [31:0]    wd_q [DEPTH];
    logic [1:0]     ln_q [DEPTH];

    logic [AW-1:0]  wptr_q, rptr_q;
    logic [AW:0]    cnt_q, cnt_d;
    logic [CNT_W-1:0] inst_q, inst_d, cyc_q, cyc_d, drop_q, drop_d;
    logic           ovf_q, end_q;
    logic [31:0]    hold_pc_q, hold_wd_q;
    logic [4:0]     hold_rd_q;
    logic [1:0]     hold_ln_q;

    logic             pop, hit;
    logic [NW-1:0]    free, nacc, ndrop, vcnt;
    logic [LANES-1:0] acc;
    logic [AW-1:0]    slot [LANES];
    logic [CNT_W:0]   inst_sum, cyc_sum, drop_sum;

    always_comb begin
        pop   = (cnt_q != '0) && out_ready;
        free  = NW'(DEPTH) - NW'(cnt_q) + NW'(pop);
        nacc  = '0;
        ndrop = '0;
        vcnt  = '0;
        hit   = 1'b0;
        acc   = '0;
        for (int i = 0; i < LANES; i++) begin
            slot[i] = wptr_q + nacc[AW-1:0];
            if (trace_en && !end_q && wb_valid[i] && wb_en[i] && wb_rd[5*i +: 5] != 5'd0) begin
                // Lanes are scanned in order, so once space runs out every later lane drops.
                if (nacc < free) begin
                    acc[i] = 1'b1;
                    nacc   = nacc + NW'(1);
                end else begin
                    ndrop  = ndrop + NW'(1);
                end
            end
            vcnt = vcnt + NW'(wb_valid[i]);
            if (wb_valid[i] && wb_pc[32*i +: 32] == END_PC) hit = 1'b1;
        end
        cnt_d    = cnt_q + (AW+1)'(nacc) - (AW+1)'(pop);
        inst_sum = {1'b0, inst_q} + (CNT_W+1)'(vcnt);
        cyc_sum  = {1'b0, cyc_q} + (CNT_W+1)'(1);
        drop_sum = {1'b0, drop_q} + (CNT_W+1)'(ndrop);
        inst_d   = inst_sum[CNT_W] ? '1 : inst_sum[CNT_W-1:0];
        cyc_d    = cyc_sum[CNT_W]  ? '1 : cyc_sum[CNT_W-1:0];
        drop_d   = drop_sum[CNT_W] ? '1 : drop_sum[CNT_W-1:0];
    end

    // Storage needs no reset: out_* is muxed to the hold registers while empty.
    always_ff @(posedge clk) begin
        for (int i = 0; i < LANES; i++) begin
            if (acc[i]) begin
                pc_q[slot[i]] <= wb_pc[32*i +: 32];
                rd_q[slot[i]] <= wb_rd[5*i +: 5];
                wd_q[slot[i]] <= wb_wdata[32*i +: 32];
                ln_q[slot[i]] <= 2'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wptr_q    <= '0;
            rptr_q    <= '0;
            cnt_q     <= '0;
            inst_q    <= '0;
            cyc_q     <= '0;
            drop_q    <= '0;
            ovf_q     <= 1'b0;
            end_q     <= 1'b0;
            hold_pc_q <= '0;
            hold_rd_q <= '0;
            hold_wd_q <= '0;
            hold_ln_q <= '0;
        end else begin
            if (pop) begin
                hold_pc_q <= pc_q[rptr_q];
                hold_rd_q <= rd_q[rptr_q];
                hold_wd_q <= wd_q[rptr_q];
                hold_ln_q <= ln_q[rptr_q];
                rptr_q    <= rptr_q + AW'(1);
            end
            wptr_q <= wptr_q + nacc[AW-1:0];
            cnt_q  <= cnt_d;
            if (!end_q) begin
                inst_q <= inst_d;
                cyc_q  <= cyc_d;
            end
            if (ndrop != '0) begin
                drop_q <= drop_d;
                ovf_q  <= 1'b1;
            end
            if (hit) end_q <= 1'b1;
        end
    end

    assign out_valid  = (cnt_q != '0);
    assign out_pc     = out_valid ? pc_q[rptr_q] : hold_pc_q;
    assign out_rd     = out_valid ? rd_q[rptr_q] : hold_rd_q;
    assign out_wdata  = out_valid ? wd_q[rptr_q] : hold_wd_q;
    assign out_lane   = out_valid ? ln_q[rptr_q] : hold_ln_q;
    assign fifo_count = cnt_q;
    assign inst_cnt   = inst_q;
    assign cycle_cnt  = cyc_q;
    assign drop_cnt   = drop_q;
    assign overflow   = ovf_q;
    assign test_end   = end_q;
endmodule

// File: tb/tb_commit_trace_serializer.sv
// Directed bench for commit_trace_serializer (LANES=2, DEPTH=4), one task per scenario.
module tb_commit_trace_serializer;
    localparam int LANES = 2;
    localparam int DEPTH = 4;
    localparam int CNT_W = 32;

    logic clk = 1'b0;
    logic resetn, trace_en, out_ready;
    logic [LANES-1:0] wb_valid, wb_en;
    logic [5*LANES-1:0] wb_rd;
    logic [32*LANES-1:0] wb_wdata, wb_pc;
    logic out_valid, overflow, test_end;
    logic [31:0] out_pc, out_wdata;
    logic [4:0] out_rd;
    logic [1:0] out_lane;
    logic [$clog2(DEPTH):0] fifo_count;
    logic [CNT_W-1:0] inst_cnt, cycle_cnt, drop_cnt;

    int vecs = 0;
    int errs = 0;

    commit_trace_serializer #(.LANES(LANES), .DEPTH(DEPTH), .CNT_W(CNT_W), .END_PC(32'hbfc00100)) dut (
        .clk(clk), .resetn(resetn), .trace_en(trace_en), .wb_valid(wb_valid), .wb_en(wb_en),
        .wb_rd(wb_rd), .wb_wdata(wb_wdata), .wb_pc(wb_pc), .out_valid(out_valid),
        .out_ready(out_ready), .out_pc(out_pc), .out_rd(out_rd), .out_wdata(out_wdata),
        .out_lane(out_lane), .fifo_count(fifo_count), .inst_cnt(inst_cnt),
        .cycle_cnt(cycle_cnt), .drop_cnt(drop_cnt), .overflow(overflow), .test_end(test_end)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_wb();
        wb_valid = '0; wb_en = '0; wb_rd = '0; wb_wdata = '0; wb_pc = '0;
    endtask

    task automatic set_lane(input int l, input logic [4:0] rd, input logic [31:0] pc, input logic [31:0] d);
        wb_valid[l] = 1'b1; wb_en[l] = 1'b1;
        wb_rd[5*l +: 5] = rd; wb_pc[32*l +: 32] = pc; wb_wdata[32*l +: 32] = d;
    endtask

    task automatic do_reset();
        clear_wb();
        out_ready = 1'b0; trace_en = 1'b1;
        resetn = 1'b0;
        step();
        resetn = 1'b1;
    endtask

    task automatic test_reset();
        clear_wb();
        trace_en = 1'b1; out_ready = 1'b0; resetn = 1'b0;
        #1;
        vecs++; if (out_valid !== 1'b0) begin errs++; $display("FAIL rst_valid got %0h want 0", out_valid); end
        vecs++; if (fifo_count !== '0) begin errs++; $display("FAIL rst_count got %0d want 0", fifo_count); end
        vecs++; if ({out_pc, out_rd, out_wdata, out_lane} !== '0) begin errs++; $display("FAIL rst_out got %0h/%0h/%0h/%0h want 0", out_pc, out_rd, out_wdata, out_lane); end
        vecs++; if ({inst_cnt, cycle_cnt, drop_cnt} !== '0) begin errs++; $display("FAIL rst_cnts got %0d/%0d/%0d want 0", inst_cnt, cycle_cnt, drop_cnt); end
        vecs++; if ({overflow, test_end} !== 2'b00) begin errs++; $display("FAIL rst_flags got %0b%0b want 00", overflow, test_end); end
        wb_valid = 2'b11;
        step(); step();
        vecs++; if ({inst_cnt, cycle_cnt} !== '0) begin errs++; $display("FAIL rst_hold_cnts got %0d/%0d want 0", inst_cnt, cycle_cnt); end
        clear_wb();
    endtask

    task automatic test_fill_drain();
        do_reset();
        for (int n = 0; n < 4; n++) begin
            clear_wb();
            set_lane(0, 5'(n + 1), 32'hbfc00000 + 32'(4 * n), 32'h1000 + 32'(n));
            step();
            if (n == 0) begin
                vecs++; if (out_valid !== 1'b1 || out_pc !== 32'hbfc00000) begin errs++; $display("FAIL fill_latency got v=%0b pc=%0h want v=1 pc=bfc00000", out_valid, out_pc); end
            end
        end
        clear_wb();
        vecs++; if (fifo_count !== 3'd4) begin errs++; $display("FAIL fill_count got %0d want 4", fifo_count); end
        vecs++; if (overflow !== 1'b0) begin errs++; $display("FAIL fill_ovf got %0b want 0", overflow); end
        vecs++; if (inst_cnt !== 32'd4 || cycle_cnt !== 32'd4) begin errs++; $display("FAIL fill_cnts got %0d/%0d want 4/4", inst_cnt, cycle_cnt); end
        out_ready = 1'b1;
        for (int n = 0; n < 4; n++) begin
            vecs++;
            if (out_valid !== 1'b1 || out_pc !== 32'hbfc00000 + 32'(4 * n) || out_rd !== 5'(n + 1) ||
                out_wdata !== 32'h1000 + 32'(n) || out_lane !== 2'd0) begin
                errs++;
                $display("FAIL drain_rec%0d got v=%0b pc=%0h rd=%0d d=%0h ln=%0d want v=1 pc=%0h rd=%0d d=%0h ln=0",
                         n, out_valid, out_pc, out_rd, out_wdata, out_lane, 32'hbfc00000 + 32'(4 * n), n + 1, 32'h1000 + 32'(n));
            end
            step();
        end
        vecs++; if (out_valid !== 1'b0 || fifo_count !== '0) begin errs++; $display("FAIL drain_empty got v=%0b cnt=%0d want 0/0", out_valid, fifo_count); end
        out_ready = 1'b0;
    endtask

    task automatic test_dual_issue();
        do_reset();
        set_lane(0, 5'd3, 32'hbfc00010, 32'haaaa0003);
        set_lane(1, 5'd4, 32'hbfc00014, 32'hbbbb0004);
        step();
        clear_wb();
        vecs++; if (fifo_count !== 3'd2 || inst_cnt !== 32'd2) begin errs++; $display("FAIL dual_cnt got cnt=%0d inst=%0d want 2/2", fifo_count, inst_cnt); end
        out_ready = 1'b1;
        vecs++; if (out_lane !== 2'd0 || out_pc !== 32'hbfc00010 || out_rd !== 5'd3) begin errs++; $display("FAIL dual_first got ln=%0d pc=%0h rd=%0d want 0/bfc00010/3", out_lane, out_pc, out_rd); end
        step();
        vecs++; if (out_lane !== 2'd1 || out_pc !== 32'hbfc00014 || out_rd !== 5'd4 || out_wdata !== 32'hbbbb0004) begin errs++; $display("FAIL dual_second got ln=%0d pc=%0h rd=%0d d=%0h want 1/bfc00014/4/bbbb0004", out_lane, out_pc, out_rd, out_wdata); end
        step();
        vecs++; if (out_valid !== 1'b0) begin errs++; $display("FAIL dual_empty got %0b want 0", out_valid); end
        out_ready = 1'b0;
    endtask

    task automatic test_filtering();
        do_reset();
        set_lane(0, 5'd0, 32'hbfc00020, 32'h1);
        set_lane(1, 5'd5, 32'hbfc00024, 32'h2);
        wb_en[1] = 1'b0;
        step();
        vecs++; if (fifo_count !== '0 || inst_cnt !== 32'd2) begin errs++; $display("FAIL filt_rd0_en0 got cnt=%0d inst=%0d want 0/2", fifo_count, inst_cnt); end
        clear_wb();
        trace_en = 1'b0;
        set_lane(0, 5'd6, 32'hbfc00028, 32'h3);
        set_lane(1, 5'd7, 32'hbfc0002c, 32'h4);
        step();
        vecs++; if (fifo_count !== '0 || inst_cnt !== 32'd4 || cycle_cnt !== 32'd2) begin errs++; $display("FAIL filt_trace_off got cnt=%0d inst=%0d cyc=%0d want 0/4/2", fifo_count, inst_cnt, cycle_cnt); end
        trace_en = 1'b1;
        clear_wb();
    endtask

    task automatic test_overflow();
        logic [4:0] exp_rd [4];
        exp_rd[0] = 5'd2; exp_rd[1] = 5'd3; exp_rd[2] = 5'd8; exp_rd[3] = 5'd9;
        do_reset();
        for (int n = 0; n < 3; n++) begin
            clear_wb();
            set_lane(0, 5'(n + 1), 32'hbfc00040 + 32'(4 * n), 32'(n));
            step();
        end
        clear_wb();
        out_ready = 1'b1;
        set_lane(0, 5'd8, 32'hbfc00050, 32'h8);
        set_lane(1, 5'd9, 32'hbfc00054, 32'h9);
        step();
        vecs++; if (fifo_count !== 3'd4 || drop_cnt !== '0 || overflow !== 1'b0) begin errs++; $display("FAIL ovf_pop_accept got cnt=%0d drop=%0d ovf=%0b want 4/0/0", fifo_count, drop_cnt, overflow); end
        clear_wb();
        out_ready = 1'b0;
        set_lane(0, 5'd10, 32'hbfc00058, 32'ha);
        set_lane(1, 5'd11, 32'hbfc0005c, 32'hb);
        step();
        clear_wb();
        vecs++; if (drop_cnt !== 32'd2 || overflow !== 1'b1 || fifo_count !== 3'd4) begin errs++; $display("FAIL ovf_drop got drop=%0d ovf=%0b cnt=%0d want 2/1/4", drop_cnt, overflow, fifo_count); end
        vecs++; if (inst_cnt !== 32'd7) begin errs++; $display("FAIL ovf_inst got %0d want 7", inst_cnt); end
        out_ready = 1'b1;
        for (int n = 0; n < 4; n++) begin
            vecs++; if (out_valid !== 1'b1 || out_rd !== exp_rd[n]) begin errs++; $display("FAIL ovf_order%0d got v=%0b rd=%0d want 1/%0d", n, out_valid, out_rd, exp_rd[n]); end
            step();
        end
        vecs++; if (out_valid !== 1'b0 || overflow !== 1'b1) begin errs++; $display("FAIL ovf_sticky got v=%0b ovf=%0b want 0/1", out_valid, overflow); end
        out_ready = 1'b0;
    endtask

    task automatic test_end_detect();
        do_reset();
        set_lane(0, 5'd1, 32'hbfc00000, 32'h11);
        step();
        clear_wb();
        set_lane(0, 5'd2, 32'hbfc000fc, 32'h22);
        set_lane(1, 5'd3, 32'hbfc00100, 32'h33);
        step();
        clear_wb();
        vecs++; if (test_end !== 1'b1) begin errs++; $display("FAIL end_set got %0b want 1", test_end); end
        vecs++; if (inst_cnt !== 32'd3 || cycle_cnt !== 32'd2 || fifo_count !== 3'd3) begin errs++; $display("FAIL end_cycle got inst=%0d cyc=%0d cnt=%0d want 3/2/3", inst_cnt, cycle_cnt, fifo_count); end
        for (int n = 0; n < 2; n++) begin
            set_lane(0, 5'd4, 32'hbfc00104, 32'h44);
            set_lane(1, 5'd5, 32'hbfc00108, 32'h55);
            step();
        end
        clear_wb();
        vecs++; if (inst_cnt !== 32'd3 || cycle_cnt !== 32'd2) begin errs++; $display("FAIL end_freeze got inst=%0d cyc=%0d want 3/2", inst_cnt, cycle_cnt); end
        vecs++; if (fifo_count !== 3'd3 || drop_cnt !== '0) begin errs++; $display("FAIL end_nopush got cnt=%0d drop=%0d want 3/0", fifo_count, drop_cnt); end
        out_ready = 1'b1;
        for (int n = 0; n < 3; n++) begin
            vecs++; if (out_valid !== 1'b1 || out_rd !== 5'(n + 1)) begin errs++; $display("FAIL end_drain%0d got v=%0b rd=%0d want 1/%0d", n, out_valid, out_rd, n + 1); end
            step();
        end
        vecs++; if (out_valid !== 1'b0 || test_end !== 1'b1) begin errs++; $display("FAIL end_after got v=%0b end=%0b want 0/1", out_valid, test_end); end
        out_ready = 1'b0;
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int n = 0; n < 3; n++) begin
            clear_wb();
            set_lane(1, 5'(n + 1), 32'hbfc00200 + 32'(4 * n), 32'hc0de0000 + 32'(n));
            step();
        end
        clear_wb();
        vecs++; if (fifo_count !== 3'd3 || out_lane !== 2'd1) begin errs++; $display("FAIL arst_pre got cnt=%0d ln=%0d want 3/1", fifo_count, out_lane); end
        #2;
        resetn = 1'b0;
        #1;
        vecs++; if (out_valid !== 1'b0 || fifo_count !== '0) begin errs++; $display("FAIL arst_fifo got v=%0b cnt=%0d want 0/0", out_valid, fifo_count); end
        vecs++; if ({out_pc, out_rd, out_wdata, out_lane} !== '0) begin errs++; $display("FAIL arst_out got %0h/%0h/%0h/%0h want 0", out_pc, out_rd, out_wdata, out_lane); end
        vecs++; if ({inst_cnt, cycle_cnt, drop_cnt, overflow, test_end} !== '0) begin errs++; $display("FAIL arst_cnts got %0d/%0d/%0d want 0", inst_cnt, cycle_cnt, drop_cnt); end
        step();
        resetn = 1'b1;
        step();
        vecs++; if (cycle_cnt !== 32'd1 || inst_cnt !== '0 || fifo_count !== '0 || out_valid !== 1'b0) begin errs++; $display("FAIL arst_restart got cyc=%0d inst=%0d cnt=%0d v=%0b want 1/0/0/0", cycle_cnt, inst_cnt, fifo_count, out_valid); end
    endtask

    initial begin
        test_reset();
        test_fill_drain();
        test_dual_issue();
        test_filtering();
        test_overflow();
        test_end_detect();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
